// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage MIPS core: per-stage stall vector,
// multi-cycle EX sequencing with an internal down-counter, and flush/redirect.
module pipe_ctrl #(
    parameter int CNT_W = 6,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic             flush_req,
    input  logic [PC_W-1:0]  flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [PC_W-1:0]  new_pc,
    output logic             mc_busy,
    output logic             mc_done
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MC    = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_new_pc;
    logic             r_flush;
    logic             r_mc_busy;
    logic             r_mc_done;
    logic [5:0]       w_stall;

    // EX outranks ID; a starting multi-cycle op stalls in its own issue cycle.
    always_comb begin
        w_stall = '0;
        if (!rst) begin
            unique case (r_state)
                MC:      w_stall = STALL_EX;
                RUN: begin
                    if (mc_start || stallreq_ex) w_stall = STALL_EX;
                    else if (stallreq_id)        w_stall = STALL_ID;
                end
                default: w_stall = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_new_pc  <= '0;
            r_flush   <= 1'b0;
            r_mc_busy <= 1'b0;
            r_mc_done <= 1'b0;
        end else begin
            r_mc_done <= 1'b0;
            if (flush_req) begin
                // Flush aborts any in-flight op silently.
                r_state   <= FLUSH;
                r_new_pc  <= flush_pc;
                r_cnt     <= '0;
                r_flush   <= 1'b1;
                r_mc_busy <= 1'b0;
            end else begin
                unique case (r_state)
                    RUN: begin
                        if (mc_start) begin
                            if (mc_cycles >= CNT_W'(2)) begin
                                r_state   <= MC;
                                r_cnt     <= mc_cycles - CNT_W'(1);
                                r_mc_busy <= 1'b1;
                            end else begin
                                r_mc_done <= 1'b1;
                            end
                        end
                    end
                    MC: begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state   <= RUN;
                            r_mc_done <= 1'b1;
                            r_mc_busy <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        r_state <= RUN;
                        r_flush <= 1'b0;
                    end
                    default: begin
                        r_state   <= RUN;
                        r_flush   <= 1'b0;
                        r_mc_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stall   = w_stall;
    assign flush   = r_flush;
    assign new_pc  = r_new_pc;
    assign mc_busy = r_mc_busy;
    assign mc_done = r_mc_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all checked
// against a remaining-cycles reference model.
module tb_pipe_ctrl;
    localparam int CNT_W = 6;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id, stallreq_ex, mc_start, flush_req;
    logic [CNT_W-1:0] mc_cycles;
    logic [PC_W-1:0]  flush_pc;
    logic [5:0]       stall;
    logic             flush, mc_busy, mc_done;
    logic [PC_W-1:0]  new_pc;

    pipe_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .mc_start(mc_start), .mc_cycles(mc_cycles),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .mc_busy(mc_busy), .mc_done(mc_done)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;

    // Reference model: flush cycle flag, redirect PC, busy cycles still owed
    // after the current one, and the done pulse.
    bit          m_flush;
    logic [31:0] m_pc;
    int          m_left;
    bit          m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_stall();
        if (rst)          return 6'b000000;
        if (m_flush)      return 6'b000000;
        if (m_left > 0)   return 6'b001111;
        if (mc_start || stallreq_ex) return 6'b001111;
        if (stallreq_id)  return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic cyc(input bit r, input bit sid, input bit sex, input bit ms,
                       input int mcy, input bit fr, input logic [31:0] fpc);
        int n;
        @(negedge clk);
        rst = r; stallreq_id = sid; stallreq_ex = sex; mc_start = ms;
        mc_cycles = mcy[CNT_W-1:0]; flush_req = fr; flush_pc = fpc;
        #1;
        chk("stall",   32'(stall),   32'(exp_stall()));
        chk("flush",   32'(flush),   32'(m_flush));
        chk("new_pc",  new_pc,       m_pc);
        chk("mc_busy", 32'(mc_busy), 32'(m_left > 0));
        chk("mc_done", 32'(mc_done), 32'(m_done));
        @(posedge clk);
        if (r) begin
            m_flush = 0; m_pc = '0; m_left = 0; m_done = 0;
        end else if (fr) begin
            m_flush = 1; m_pc = fpc; m_left = 0; m_done = 0;
        end else if (m_flush) begin
            m_flush = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
        end else if (ms) begin
            n = (mcy < 1) ? 1 : mcy;
            m_left = n - 1;
            m_done = (n == 1);
        end else begin
            m_done = 0;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, '0);
    endtask

    int done_seen;

    initial begin
        rst = 1; stallreq_id = 0; stallreq_ex = 0; mc_start = 0;
        mc_cycles = '0; flush_req = 0; flush_pc = '0;
        m_flush = 0; m_pc = '0; m_left = 0; m_done = 0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 5, 1, 32'hDEAD);
        idle(2);

        // ID stall, then EX outranks ID
        cyc(0, 1, 0, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, 0, 0, '0);
        cyc(0, 1, 1, 0, 0, 0, '0);
        idle(1);

        // 32-cycle DIV: exactly one done pulse, after the busy window
        done_seen = 0;
        cyc(0, 0, 0, 1, 32, 0, '0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, i[0], 1, 1, 3, 0, '0);
            #1 if (mc_done) done_seen++;
        end
        chk("div32_done_cnt", 32'(done_seen), 32'd1);
        idle(2);

        // degenerate lengths
        cyc(0, 0, 0, 1, 1, 0, '0);
        idle(2);
        cyc(0, 0, 0, 1, 0, 0, '0);
        idle(2);
        cyc(0, 0, 0, 1, 2, 0, '0);
        idle(3);

        // flush aborts an 8-cycle op
        cyc(0, 0, 0, 1, 8, 0, '0);
        idle(3);
        cyc(0, 0, 0, 0, 0, 1, 32'hBFC00380);
        #1 chk("redir_pc", new_pc, 32'hBFC00380);
        chk("redir_flush", 32'(flush), 32'd1);
        idle(10);

        // back-to-back flush
        cyc(0, 0, 0, 0, 0, 1, 32'h100);
        cyc(0, 0, 0, 0, 0, 1, 32'h200);
        #1 chk("flush2_pc", new_pc, 32'h200);
        idle(3);
        chk("pc_hold", new_pc, 32'h200);

        // flush with start, flush on the finishing cycle, mc_start during FLUSH
        cyc(0, 0, 0, 1, 5, 1, 32'h300);
        cyc(0, 1, 1, 1, 5, 0, '0);
        idle(1);
        cyc(0, 0, 0, 1, 3, 0, '0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 32'h400);
        idle(3);

        // reset mid-op
        cyc(0, 0, 0, 1, 8, 0, '0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, '0);
        idle(10);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 40),
                $urandom_range(0, 29) == 0,
                $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It turns the stall requests from ID and EX into one per-stage stall vector. It sequences multi-cycle EX operations (DIV, MADD/MSUB) with an internal down-counter, so EX only pulses a start. It issues single-cycle pipeline flushes with a redirect PC. It sits beside the stage registers, which consume `stall`/`flush`, and beside `pc_reg`, which consumes `new_pc`.

## Interface
Parameters:
- `CNT_W`, 6: width of the multi-cycle count; must hold the largest latency, 32 for DIV.
- `PC_W`, 32: width of `flush_pc` and `new_pc`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_id`  in  1  ID requests a stall, e.g. a load-use hazard.
- `stallreq_ex`  in  1  EX requests a stall for this cycle.
- `mc_start`  in  1  one-cycle pulse: EX begins a multi-cycle op.
- `mc_cycles`  in  CNT_W  total EX occupancy in cycles; sampled with `mc_start`.
- `flush_req`  in  1  flush the pipeline and redirect to `flush_pc`.
- `flush_pc`  in  PC_W  redirect address; sampled with `flush_req`.
- `stall`  out  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush`  out  1  registered; clears all stage registers for one cycle.
- `new_pc`  out  PC_W  registered redirect PC; valid while `flush`=1.
- `mc_busy`  out  1  registered; high while in state MC.
- `mc_done`  out  1  registered one-cycle pulse; the multi-cycle op has completed.

## Operation
- States: RUN, MC, FLUSH. A down-counter `cnt` of width CNT_W.
- `stall` is combinational from state and inputs:
  - rst=1 -> 6'b000000.
  - FLUSH -> 6'b000000.
  - MC -> 6'b001111.
  - RUN:
    - `mc_start` or `stallreq_ex` -> 6'b001111.
    - else `stallreq_id` -> 6'b000111.
    - else 6'b000000.
  - EX takes priority over ID.
- `flush_req` has the highest priority in every state:
  - Next state is FLUSH.
  - `new_pc` <= `flush_pc`.
  - `cnt` <= 0.
  - Any MC in progress is aborted with no `mc_done`.
- RUN transitions:
  - `mc_start`, `mc_cycles` >= 2 -> MC, `cnt` <= `mc_cycles`-1.
  - `mc_start`, `mc_cycles` in {0,1} -> stay RUN, `mc_done` <= 1. A value of 0 is treated as 1.
  - Otherwise stay RUN.
- MC:
  - `cnt` decrements each cycle.
  - When `cnt`==1 -> RUN, `mc_done` <= 1.
  - `mc_start`, `stallreq_id` and `stallreq_ex` are ignored.
- FLUSH:
  - `flush`=1 for exactly this cycle.
  - Next state is RUN, unless `flush_req` is high again: then stay FLUSH and reload `new_pc`.
  - `mc_start` is ignored.
- `mc_busy` = (state==MC). `mc_done` is 0 in every cycle where it is not set above.
- `new_pc` holds its last value outside FLUSH.

## Timing
- Reset values:
  - state RUN, `cnt`=0.
  - `flush`=0, `new_pc`=0, `mc_busy`=0, `mc_done`=0.
  - `stall`=0 while rst is high.
- Multi-cycle op with `mc_start` in cycle T and `mc_cycles`=N>=2:
  - `stall`=001111 in cycles T..T+N-1, N cycles in total.
  - `mc_busy`=1 in cycles T+1..T+N-1.
  - In cycle T+N: `mc_done`=1 and the stall is released, unless another request is active.
- N<=1: stall only in cycle T; `mc_done`=1 in T+1.
- Flush latency: `flush_req` in T gives `flush`=1 and `new_pc` valid in T+1, with `stall`=0 in T+1.
  - `stall` in cycle T itself follows the current state and inputs.
- `flush_req` and `mc_start` in the same cycle: flush wins and MC is never entered.
- `flush_req` in the same cycle MC would finish (`cnt`==1): flush wins and there is no `mc_done`.
- Reset asserted mid-MC: RUN on the next edge; no `mc_done`, no flush.

## Test plan
- Reset hold 3 cycles, then release -> `stall`=0, `flush`=0, `new_pc`=0, `mc_busy`=0, `mc_done`=0.
- `stallreq_id`=1 for 2 cycles, then `stallreq_ex` and `stallreq_id` both 1 for 1 cycle -> `stall`=000111, 000111, then 001111, then 000000.
- `mc_start` with `mc_cycles`=32 in T -> `stall`=001111 for T..T+31, `mc_busy` high T+1..T+31, `mc_done` pulse in T+32 only, `stall`=0 in T+32.
- `mc_start` with `mc_cycles`=1, then `mc_cycles`=0 -> one stall cycle each, followed by an `mc_done` pulse; `mc_busy` never rises.
- `mc_start` with `mc_cycles`=8 in T, `flush_req` with `flush_pc`=32'hBFC00380 in T+4 -> `flush`=1 and `new_pc`=32'hBFC00380 in T+5, `stall`=0 in T+5, no `mc_done` ever, RUN in T+6.
- `flush_req` held high 2 cycles with `flush_pc` 32'h100 then 32'h200 -> `flush`=1 for 2 cycles with `new_pc` 32'h100 then 32'h200; `flush`=0 afterwards and `new_pc` stays at 32'h200.
